seg_scan_ctrl: RTL and testbench

Multiplexed seven-segment display scanner placed directly downstream of the 16-line priority-encoder / BCD-to-7-segment decoder stage. It captures that stage's 8-bit segment output Y into a per-digit buffer and time-multiplexes the buffer onto one shared segment bus with one-hot digit selects. It drives a common-cathode module: SEG is active-high and DIG is active-low.

---
 rtl/seg_scan_ctrl.sv | 161 ++++++++++++++++
 tb/tb_seg_scan_ctrl.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_ctrl.sv
// Multiplexed seven-segment scanner: per-digit buffer, BLANK/SHOW scan, one-hot active-low digit select.
// Optional build macro SCAN_BLINK_EN adds a frame-based blink of digits selected by BLINK_MASK.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_BLANK | all digits off for BLANK_CYC cycles (anti-ghosting gap)
// ST_SHOW  | digit idx driven with its snapshot for SHOW_CYC cycles
module seg_scan_ctrl #(
  parameter int NUM_DIG      = 8,
  parameter int SHOW_CYC     = 50000,
  parameter int BLANK_CYC    = 64,
  parameter int BLINK_FRAMES = 128
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               WR_EN,
  input  logic [2:0]         WR_ADDR,
  input  logic [7:0]         WR_DATA,
  input  logic               CLR,
  input  logic [NUM_DIG-1:0] EN_DIGITS,
  input  logic [NUM_DIG-1:0] BLINK_MASK,
  output logic [7:0]         SEG,
  output logic [NUM_DIG-1:0] DIG,
  output logic               FRAME
);

  localparam int IW   = $clog2(NUM_DIG);
  localparam int CMAX = (SHOW_CYC > BLANK_CYC) ? SHOW_CYC : BLANK_CYC;
  localparam int CW   = $clog2(CMAX + 1);

  typedef enum logic {ST_BLANK, ST_SHOW} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            wrap, wrap_q;
  logic            enter_show;
  logic            wr_ok;
  logic [7:0]      snap_q, snap_d;
  logic [7:0]      dbuf_q [NUM_DIG];
  logic            blink_hide;
  logic            show_on;

  // scan state register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_BLANK;
      cnt_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + CW'(1);
    idx_d      = idx_q;
    wrap       = 1'b0;
    enter_show = 1'b0;
    case (state_q)
      ST_BLANK: begin
        if (cnt_q == CW'(BLANK_CYC - 1)) begin
          state_d    = ST_SHOW;
          cnt_d      = '0;
          enter_show = 1'b1;
        end
      end
      ST_SHOW: begin
        if (cnt_q == CW'(SHOW_CYC - 1)) begin
          state_d = ST_BLANK;
          cnt_d   = '0;
          if (idx_q == IW'(NUM_DIG - 1)) begin
            idx_d = '0;
            wrap  = 1'b1;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      default: begin
        state_d = ST_BLANK;
        cnt_d   = '0;
      end
    endcase
  end

  assign wr_ok = WR_EN && (32'(WR_ADDR) < NUM_DIG);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < NUM_DIG; i++) dbuf_q[i] <= '0;
    end else if (CLR) begin
      for (int i = 0; i < NUM_DIG; i++) dbuf_q[i] <= '0;
    end else if (wr_ok) begin
      dbuf_q[WR_ADDR[IW-1:0]] <= WR_DATA;
    end
  end

  // snapshot takes the post-edge buffer value, so a same-edge write (or clear) is seen
  always_comb begin
    snap_d = dbuf_q[idx_q];
    if (CLR)
      snap_d = '0;
    else if (wr_ok && (WR_ADDR == 3'(idx_q)))
      snap_d = WR_DATA;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)
      snap_q <= '0;
    else if (enter_show)
      snap_q <= snap_d;
  end

`ifdef SCAN_BLINK_EN
  localparam int FW = $clog2(BLINK_FRAMES) + 1;
  logic [FW-1:0] fcnt_q;
  logic          blink_on_q;

  // blink phase only flips on a FRAME pulse, so a frame is never split
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      fcnt_q     <= '0;
      blink_on_q <= 1'b1;
    end else if (FRAME) begin
      if (fcnt_q == FW'(BLINK_FRAMES - 1)) begin
        fcnt_q     <= '0;
        blink_on_q <= ~blink_on_q;
      end else begin
        fcnt_q <= fcnt_q + FW'(1);
      end
    end
  end

  assign blink_hide = ~blink_on_q & BLINK_MASK[idx_q];
`else
  logic unused_blink;
  assign unused_blink = ^BLINK_MASK;
  assign blink_hide   = 1'b0;
`endif

  assign show_on = (state_q == ST_SHOW) && EN_DIGITS[idx_q] && !blink_hide;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      SEG    <= '0;
      DIG    <= '1;
      wrap_q <= 1'b0;
      FRAME  <= 1'b0;
    end else begin
      SEG    <= show_on ? snap_q : 8'h00;
      DIG    <= show_on ? ~(NUM_DIG'(1) << idx_q) : '1;
      wrap_q <= wrap;
      FRAME  <= wrap_q;
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl (4 digits, SHOW=4, BLANK=2, BLINK_FRAMES=2).
// A cycle-position reference model checks every cycle; checkpoint tables and directed sequences cover corners.
module tb_seg_scan_ctrl;
  localparam int ND = 4, SC = 4, BC = 2, BF = 2;
  localparam int SLOT = SC + BC;
  localparam int FLEN = ND * SLOT;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b1;
  logic       WR_EN = 1'b0;
  logic [2:0] WR_ADDR = '0;
  logic [7:0] WR_DATA = '0;
  logic       CLR = 1'b0;
  logic [3:0] EN_DIGITS = 4'hF;
  logic [3:0] BLINK_MASK = 4'h0;
  logic [7:0] SEG;
  logic [3:0] DIG;
  logic       FRAME;

  always #5 CLK = ~CLK;

  seg_scan_ctrl #(.NUM_DIG(ND), .SHOW_CYC(SC), .BLANK_CYC(BC), .BLINK_FRAMES(BF)) dut (
    .CLK(CLK), .RST_N(RST_N), .WR_EN(WR_EN), .WR_ADDR(WR_ADDR), .WR_DATA(WR_DATA),
    .CLR(CLR), .EN_DIGITS(EN_DIGITS), .BLINK_MASK(BLINK_MASK),
    .SEG(SEG), .DIG(DIG), .FRAME(FRAME)
  );

  int nchk = 0, nfail = 0;
  int k = 0;                 // edges since reset release
  logic [7:0] mbuf [ND];
  logic [7:0] msnap;

  typedef struct { int k; logic [3:0] dig; logic [7:0] seg; logic frame; } cp_t;
  typedef struct { logic [2:0] addr; logic [7:0] data; } wr_t;
  cp_t cps [11];
  wr_t wrs [4];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s k=%0d got=%h expected=%h", name, k, got, exp);
    end
  endtask

  // one clock edge: predict from cycle position and current inputs, then compare
  task automatic tick();
    int q, s, r;
    logic en;
    logic [7:0] eseg;
    logic [3:0] edig;
    logic efr;
    k++;
    q = (k - 1) % FLEN;
    s = q / SLOT;
    r = q % SLOT;
    en = EN_DIGITS[s];
`ifdef SCAN_BLINK_EN
    if (((((k - 1) / FLEN) / BF) % 2) == 1 && BLINK_MASK[s]) en = 1'b0;
`endif
    eseg = 8'h00;
    edig = 4'hF;
    if (r >= BC && en) begin
      eseg = msnap;
      edig = ~(4'b0001 << s);
    end
    efr = (q == 0) && (k > 1);
    if (CLR) begin
      for (int i = 0; i < ND; i++) mbuf[i] = 8'h00;
    end else if (WR_EN && WR_ADDR < ND) begin
      mbuf[WR_ADDR] = WR_DATA;
    end
    if (r == BC - 1) msnap = mbuf[s];
    @(posedge CLK);
    #1;
    chk("scan", {SEG, DIG, FRAME}, {eseg, edig, efr});
  endtask

  task automatic run_to(input int kt);
    while (k < kt) tick();
  endtask

  task automatic write_step(input logic [2:0] a, input logic [7:0] d);
    WR_EN = 1'b1; WR_ADDR = a; WR_DATA = d;
    tick();
    WR_EN = 1'b0;
  endtask

  task automatic do_reset();
    WR_EN = 1'b0; CLR = 1'b0;
    #2;
    RST_N = 1'b0;
    #1;
    chk("reset_async", {SEG, DIG, FRAME}, {8'h00, 4'hF, 1'b0});
    @(posedge CLK);
    #2;
    chk("reset_hold", {SEG, DIG, FRAME}, {8'h00, 4'hF, 1'b0});
    RST_N = 1'b1;
    k = 0;
    for (int i = 0; i < ND; i++) mbuf[i] = 8'h00;
    msnap = 8'h00;
  endtask

  initial begin
    bit did_rst;
    wrs[0] = '{3'd0, 8'h3F}; wrs[1] = '{3'd1, 8'h06};
    wrs[2] = '{3'd2, 8'h5B}; wrs[3] = '{3'd3, 8'h4F};
    cps[0]  = '{7,  4'hF, 8'h00, 1'b0};
    cps[1]  = '{9,  4'hD, 8'h06, 1'b0};
    cps[2]  = '{12, 4'hD, 8'h06, 1'b0};
    cps[3]  = '{13, 4'hF, 8'h00, 1'b0};
    cps[4]  = '{15, 4'hB, 8'h5B, 1'b0};
    cps[5]  = '{21, 4'h7, 8'h4F, 1'b0};
    cps[6]  = '{24, 4'h7, 8'h4F, 1'b0};
    cps[7]  = '{25, 4'hF, 8'h00, 1'b1};
    cps[8]  = '{26, 4'hF, 8'h00, 1'b0};
    cps[9]  = '{27, 4'hE, 8'h3F, 1'b0};
    cps[10] = '{31, 4'hF, 8'h00, 1'b0};

    do_reset();

    // basic scan with four decoder codes
    for (int i = 0; i < 4; i++) write_step(wrs[i].addr, wrs[i].data);
    for (int i = 0; i < 11; i++) begin
      run_to(cps[i].k);
      chk("table_cp", {SEG, DIG, FRAME}, {cps[i].seg, cps[i].dig, cps[i].frame});
    end

    // write to the digit currently being shown: no tearing
    run_to(33);
    write_step(3'd1, 8'h6D);
    run_to(36);
    chk("no_tear_seg", SEG, 8'h06);
    run_to(57);
    chk("next_visit_seg", {SEG, DIG}, {8'h6D, 4'hD});

    // CLR wins over a same-edge write
    run_to(59);
    WR_EN = 1'b1; WR_ADDR = 3'd2; WR_DATA = 8'h7F; CLR = 1'b1;
    tick();
    WR_EN = 1'b0; CLR = 1'b0;
    run_to(63);
    chk("clr_wins_d2", {SEG, DIG}, {8'h00, 4'hB});
    run_to(69);
    chk("clr_all_d3", {SEG, DIG}, {8'h00, 4'h7});

    // digit 2 disabled; scan timing unchanged
    EN_DIGITS = 4'b1011;
    for (int i = 0; i < 4; i++) write_step(wrs[i].addr, wrs[i].data);
    run_to(75);
    chk("en_d0", {SEG, DIG}, {8'h3F, 4'hE});
    run_to(85);
    chk("en_off_d2", {SEG, DIG}, {8'h00, 4'hF});
    run_to(93);
    chk("en_d3", {SEG, DIG}, {8'h4F, 4'h7});
    run_to(96);
    chk("frame_lo", FRAME, 1'b0);
    run_to(97);
    chk("frame_period", FRAME, 1'b1);

    // randomized traffic, with one reset landing mid-SHOW of digit 3
    did_rst = 1'b0;
    for (int i = 0; i < 600; i++) begin
      WR_EN   = ($urandom_range(0, 2) == 0);
      WR_ADDR = 3'($urandom_range(0, 7));
      WR_DATA = 8'($urandom);
      CLR     = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 7) == 0) EN_DIGITS = 4'($urandom);
      if ($urandom_range(0, 15) == 0) BLINK_MASK = 4'($urandom);
      tick();
      if (!did_rst && i > 200 && ((k - 1) % FLEN) >= 20 && ((k - 1) % FLEN) <= 22) begin
        did_rst = 1'b1;
        do_reset();
        EN_DIGITS = 4'hF;
        run_to(2);
        chk("post_rst_blank", {SEG, DIG}, {8'h00, 4'hF});
        run_to(3);
        chk("post_rst_d0", {SEG, DIG}, {8'h00, 4'hE});
      end
    end
    chk("rst_mid_show_hit", {31'd0, did_rst}, 32'd1);

`ifdef SCAN_BLINK_EN
    do_reset();
    EN_DIGITS = 4'hF;
    BLINK_MASK = 4'b0001;
    write_step(3'd0, 8'h3F);
    write_step(3'd1, 8'h06);
    for (int f = 0; f < 6; f++) begin
      run_to(f * FLEN + BC + 1);
      chk("blink_d0", {SEG, DIG}, ((f / BF) % 2 == 1) ? {8'h00, 4'hF} : {8'h3F, 4'hE});
      run_to(f * FLEN + SLOT + BC + 1);
      chk("blink_d1", {SEG, DIG}, {8'h06, 4'hD});
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
